// File: rtl/r88_pkg.sv
// Shared constants for the Rocket88 register-block sequencer:
// FSM encoding, grant identifiers and default register index width.
package r88_pkg;

    localparam int unsigned R88_ADDR_W = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_B0   = 2'd1;
    localparam logic [1:0] ST_B1   = 2'd2;
    localparam logic [1:0] ST_LAST = 2'd3;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    // Transaction fields latched at grant time (address kept separately, it is parameterised).
    typedef struct packed {
        logic        owner;
        logic        wr;
        logic        pair;
        logic [15:0] wdata;
    } r88_txn_t;

endpackage

// File: rtl/r88_rr_arb.sv
// Two-way arbiter: round-robin on ties when RR_EN=1, else A always wins ties.
// Holds the last grant; one-hot grants are combinational and gated by enable.
module r88_rr_arb
    import r88_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic enable,
    output logic grant_a_c,
    output logic grant_b_c
);

    logic last_grant;

    always_comb begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        if (enable) begin
            if (req_a && req_b) begin
                if (RR_EN && (last_grant == GRANT_A)) begin
                    grant_b_c = 1'b1;
                end else begin
                    grant_a_c = 1'b1;
                end
            end else begin
                grant_a_c = req_a;
                grant_b_c = req_b;
            end
        end
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= GRANT_B;
        end else if (grant_a_c) begin
            last_grant <= GRANT_A;
        end else if (grant_b_c) begin
            last_grant <= GRANT_B;
        end
    end

endmodule

// File: rtl/r88_regseq.sv
// Rocket88 register-block sequencer: arbitrates two requesters onto the byte port,
// splits pair transfers into two byte cycles and assembles read results.
module r88_regseq
    import r88_pkg::*;
#(
    parameter int unsigned ADDR_W = R88_ADDR_W,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              sysClock,
    input  logic              sysResetN,
    input  logic              aReq,
    input  logic              aWr,
    input  logic              aPair,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [15:0]       aWData,
    output logic              aDone,
    output logic [15:0]       aRData,
    input  logic              bReq,
    input  logic              bWr,
    input  logic              bPair,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [15:0]       bWData,
    output logic              bDone,
    output logic [15:0]       bRData,
    output logic [ADDR_W-1:0] rbSel,
    output logic              rbRead,
    output logic              rbWrite,
    output logic [7:0]        rbDOut,
    input  logic [7:0]        rbDIn,
    output logic              busy
);

    logic [1:0]        state, state_d;
    r88_txn_t          txn, txn_d;
    logic [ADDR_W-1:0] txn_addr, addr_d;
    logic [7:0]        lo_byte, lo_byte_d;

    logic [ADDR_W-1:0] sel_d;
    logic              read_d, write_d, busy_d;
    logic [7:0]        dout_d;
    logic              a_done_d, b_done_d;
    logic [15:0]       a_rdata_d, b_rdata_d;
    logic [15:0]       result_c;
    logic              grant_a_c, grant_b_c;

    r88_rr_arb #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk       (sysClock),
        .rst_n     (sysResetN),
        .req_a     (aReq),
        .req_b     (bReq),
        .enable    (state == ST_IDLE),
        .grant_a_c (grant_a_c),
        .grant_b_c (grant_b_c)
    );

    // Next state and next registered outputs; strobes are issued on entry to B0/B1.
    always_comb begin
        state_d   = state;
        txn_d     = txn;
        addr_d    = txn_addr;
        lo_byte_d = lo_byte;
        sel_d     = '0;
        read_d    = 1'b0;
        write_d   = 1'b0;
        dout_d    = 8'h00;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_rdata_d = aRData;
        b_rdata_d = bRData;
        result_c  = 16'h0000;

        case (state)
            ST_IDLE: begin
                if (grant_a_c || grant_b_c) begin
                    txn_d.owner = grant_a_c ? GRANT_A : GRANT_B;
                    txn_d.wr    = grant_a_c ? aWr    : bWr;
                    txn_d.pair  = grant_a_c ? aPair  : bPair;
                    txn_d.wdata = grant_a_c ? aWData : bWData;
                    // Pairs always start on an even register.
                    addr_d  = (grant_a_c ? aAddr : bAddr) & ~ADDR_W'(txn_d.pair);
                    sel_d   = addr_d;
                    read_d  = !txn_d.wr;
                    write_d = txn_d.wr;
                    dout_d  = txn_d.wr ? txn_d.wdata[7:0] : 8'h00;
                    state_d = ST_B0;
                end
            end
            ST_B0: begin
                if (txn.pair) begin
                    sel_d   = txn_addr | ADDR_W'(1);
                    read_d  = !txn.wr;
                    write_d = txn.wr;
                    dout_d  = txn.wr ? txn.wdata[15:8] : 8'h00;
                    state_d = ST_B1;
                end else begin
                    state_d = ST_LAST;
                end
            end
            ST_B1: begin
                if (!txn.wr) begin
                    lo_byte_d = rbDIn;
                end
                state_d = ST_LAST;
            end
            ST_LAST: begin
                result_c = txn.pair ? {rbDIn, lo_byte} : {8'h00, rbDIn};
                if (txn.owner == GRANT_A) begin
                    a_done_d = 1'b1;
                    if (!txn.wr) begin
                        a_rdata_d = result_c;
                    end
                end else begin
                    b_done_d = 1'b1;
                    if (!txn.wr) begin
                        b_rdata_d = result_c;
                    end
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sysClock) begin
        if (!sysResetN) begin
            state    <= ST_IDLE;
            txn      <= '0;
            txn_addr <= '0;
            lo_byte  <= 8'h00;
            rbSel    <= '0;
            rbRead   <= 1'b0;
            rbWrite  <= 1'b0;
            rbDOut   <= 8'h00;
            aDone    <= 1'b0;
            bDone    <= 1'b0;
            aRData   <= 16'h0000;
            bRData   <= 16'h0000;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            txn      <= txn_d;
            txn_addr <= addr_d;
            lo_byte  <= lo_byte_d;
            rbSel    <= sel_d;
            rbRead   <= read_d;
            rbWrite  <= write_d;
            rbDOut   <= dout_d;
            aDone    <= a_done_d;
            bDone    <= b_done_d;
            aRData   <= a_rdata_d;
            bRData   <= b_rdata_d;
            busy     <= busy_d;
        end
    end

endmodule
